// File: rtl/nec_uart_pkg.sv
// Shared types, character constants and helpers for the NEC IR to UART transmitter.
package nec_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       is_repeat;
        logic [7:0] data;
    } fifo_entry_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_R  = 8'h52;

    // Uppercase hex digit: 0-9 map to '0'..'9', A-F map to 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/nec_uart_fifo.sv
// Show-ahead synchronous FIFO; rdata always presents the oldest entry.
module nec_uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok, pop_ok;

    // Full is judged on the pre-edge count, so a push while full is lost even if a pop frees a slot.
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
        end
    end

    // NOTE: storage needs no reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nec_uart_tx.sv
// NEC decoder output to UART 8N1 transmitter with a small entry FIFO.
// Define NEC_UART_ASCII_EN to send entries as ASCII hex + CR/LF instead of raw bytes.
module nec_uart_tx
    import nec_uart_pkg::*;
#(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         BAUD        = 115200,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] REPEAT_BYTE = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_en,
    input  logic       repeat_in_en,
    output logic       uart_txd,
    output logic       busy,
    output logic       overflow
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    fifo_entry_t      push_entry, fifo_rdata;
    logic             push_req, fifo_pop, fifo_full, fifo_empty;
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic             txd_q, txd_d, busy_q, overflow_q, baud_tc;
`ifdef NEC_UART_ASCII_EN
    logic [1:0]       char_q, char_d;
    fifo_entry_t      entry_q, entry_d;

    function automatic logic [7:0] ascii_char(input fifo_entry_t e, input logic [1:0] idx);
        if (e.is_repeat) begin
            case (idx)
                2'd0:    return ASCII_R;
                2'd1:    return ASCII_CR;
                default: return ASCII_LF;
            endcase
        end else begin
            case (idx)
                2'd0:    return hex_to_ascii(e.data[7:4]);
                2'd1:    return hex_to_ascii(e.data[3:0]);
                2'd2:    return ASCII_CR;
                default: return ASCII_LF;
            endcase
        end
    endfunction
`endif

    // A data strobe wins over a simultaneous repeat strobe.
    always_comb begin
        push_entry.is_repeat = ~data_in_en;
        push_entry.data      = data_in_en ? data_in : 8'h00;
    end
    assign push_req = data_in_en | repeat_in_en;

    nec_uart_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .push (push_req),
        .pop  (fifo_pop),
        .wdata(push_entry),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign baud_tc = (cnt_q == CNT_W'(DIV - 1));

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        fifo_pop = 1'b0;
`ifdef NEC_UART_ASCII_EN
        char_d   = char_q;
        entry_d  = entry_q;
`endif
        if (state_q != IDLE) cnt_d = baud_tc ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = START;
`ifdef NEC_UART_ASCII_EN
                    entry_d  = fifo_rdata;
                    char_d   = 2'd0;
                    byte_d   = ascii_char(fifo_rdata, 2'd0);
`else
                    byte_d   = fifo_rdata.is_repeat ? REPEAT_BYTE : fifo_rdata.data;
`endif
                end
            end
            START: if (baud_tc) state_d = DATA;
            DATA: begin
                if (baud_tc) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    state_d = IDLE;
`ifdef NEC_UART_ASCII_EN
                    // Remaining characters of a group follow with no idle cycle.
                    if (char_q != (entry_q.is_repeat ? 2'd2 : 2'd3)) begin
                        char_d  = char_q + 2'd1;
                        byte_d  = ascii_char(entry_q, char_q + 2'd1);
                        state_d = START;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = byte_q[bit_q];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef NEC_UART_ASCII_EN
            char_q     <= '0;
            entry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            txd_q      <= txd_d;
            busy_q     <= ~fifo_empty | (state_q != IDLE);
            overflow_q <= overflow_q | (push_req & fifo_full);
`ifdef NEC_UART_ASCII_EN
            char_q     <= char_d;
            entry_q    <= entry_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
